// File: rtl/uart_apb_regs_if.sv
// rtl/uart_apb_regs_if.sv - APB3 bus bundle between the CPU side and uart_apb_regs
//
// Purpose : groups the APB3 transfer signals so the register bridge and its
//           bus master share one port.
// Signals : psel, penable, pwrite, paddr[ADDR_W], pwdata[32]  (master -> slave)
//           prdata[32], pready, pslverr                       (slave -> master)
interface uart_apb_regs_if #(
  parameter int ADDR_W = 4
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uart_apb_regs.sv
// rtl/uart_apb_regs.sv - APB3 register bridge feeding the UART TX/RX FIFOs and baud generator
//
// Purpose : decodes APB3 transfers into TX FIFO pushes, RX FIFO pops, baud
//           divisor programming and status reads.
// Ports   : clk, reset (async, active low)
//           bus              APB3 slave (uart_apb_regs_if.slave)
//           tx_fifo_dataIn   byte pushed to the TX FIFO
//           tx_fifo_writeEn  one-cycle push strobe
//           tx_fifo_Full     TX FIFO full
//           rx_fifo_readEn   one-cycle pop strobe
//           rx_fifo_Empty    RX FIFO empty
//           rx_fifo_dataOut  RX FIFO head, valid the cycle after readEn
//           baud_final_value baud divisor
//           irq              interrupt request
// Options : UART_APB_IRQ_EN adds the IRQ_EN register and a registered irq;
//           without it irq is tied low and IRQ_EN reads zero.
// Map     : paddr[3:2] 0=DATA 1=STATUS 2=BAUD 3=IRQ_EN
module uart_apb_regs #(
  parameter int          ADDR_W   = 4,
  parameter logic [10:0] BAUD_RST = 11'd325
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_apb_regs_if.slave       bus,
  output logic [7:0]           tx_fifo_dataIn,
  output logic                 tx_fifo_writeEn,
  input  logic                 tx_fifo_Full,
  output logic                 rx_fifo_readEn,
  input  logic                 rx_fifo_Empty,
  input  logic [7:0]           rx_fifo_dataOut,
  output logic [10:0]          baud_final_value,
  output logic                 irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [10:0]       baud;
  logic              tx_ovf;
  logic              rx_udf;
  logic [ADDR_W-1:0] paddr;
  logic [1:0]        reg_idx;
  logic              access;
  logic              is_data;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_udf;
  logic              status_wr;
  logic [31:0]       irq_en_rd;
  logic [31:0]       rdata;

  assign paddr   = bus.paddr;
  assign reg_idx = paddr[3:2];
  assign is_data = (reg_idx == 2'd0);

  // Side effects only fire in a genuine ACCESS phase; if the master abandons
  // the transfer the FSM simply falls back to IDLE.
  assign access    = (state == ACCESS) && bus.psel && bus.penable;
  assign push      = access &&  bus.pwrite && is_data && !tx_fifo_Full;
  assign set_ovf   = access &&  bus.pwrite && is_data &&  tx_fifo_Full;
  assign pop       = access && !bus.pwrite && is_data && !rx_fifo_Empty;
  assign set_udf   = access && !bus.pwrite && is_data &&  rx_fifo_Empty;
  assign status_wr = access &&  bus.pwrite && (reg_idx == 2'd1);

  // Strobes and bus response are decoded from the state so that zero-wait
  // transfers complete in the first ACCESS cycle, and an async reset (which
  // forces IDLE) drops them immediately.
  assign tx_fifo_writeEn  = push;
  assign tx_fifo_dataIn   = push ? bus.pwdata[7:0] : 8'h00;
  assign rx_fifo_readEn   = pop;
  assign bus.pready       = (access && !pop) || (state == RD_WAIT);
  assign bus.pslverr      = set_ovf || set_udf;
  assign bus.prdata       = rdata;
  assign baud_final_value = baud;

  always_comb begin
    rdata = 32'h0;
    if (state == RD_WAIT) begin
      rdata = {24'h0, rx_fifo_dataOut};
    end else if (access && !bus.pwrite) begin
      case (reg_idx)
        2'd1:    rdata = {28'h0, rx_udf, tx_ovf, rx_fifo_Empty, tx_fifo_Full};
        2'd2:    rdata = {21'h0, baud};
        2'd3:    rdata = irq_en_rd;
        default: rdata = 32'h0;  // DATA read with empty FIFO returns zero
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      baud  <= BAUD_RST;
    end else begin
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) state <= ACCESS;
        end
        ACCESS: begin
          if (pop) begin
            state <= RD_WAIT;
          end else begin
            state <= IDLE;
            if (access && bus.pwrite && (reg_idx == 2'd2)) baud <= bus.pwdata[10:0];
          end
        end
        // The pop already happened, so finish even if psel has gone away.
        RD_WAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags: write-1-to-clear, with a same-cycle set taking priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      tx_ovf <= set_ovf || (tx_ovf && !(status_wr && bus.pwdata[2]));
      rx_udf <= set_udf || (rx_udf && !(status_wr && bus.pwdata[3]));
    end
  end

`ifdef UART_APB_IRQ_EN
  logic [2:0] irq_en;
  logic       irq_q;

  assign irq_en_rd = {29'h0, irq_en};
  assign irq       = irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 3'b000;
      irq_q  <= 1'b0;
    end else begin
      if (access && bus.pwrite && (reg_idx == 2'd3)) irq_en <= bus.pwdata[2:0];
      irq_q <= |(irq_en & {tx_ovf | rx_udf, !tx_fifo_Full, !rx_fifo_Empty});
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.pwdata[31:11], paddr[1:0]};
`else
  assign irq_en_rd = 32'h0;
  assign irq       = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.pwdata[31:11], paddr[1:0]};
`endif

endmodule

// File: tb/tb_uart_apb_regs.sv
// tb/tb_uart_apb_regs.sv - directed table-driven bench for uart_apb_regs
module tb_uart_apb_regs;

`ifdef UART_APB_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  tx_fifo_dataIn;
  logic        tx_fifo_writeEn;
  logic        tx_fifo_Full;
  logic        rx_fifo_readEn;
  logic        rx_fifo_Empty;
  logic [7:0]  rx_fifo_dataOut;
  logic [10:0] baud_final_value;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  uart_apb_regs_if #(.ADDR_W(4)) bus ();

  uart_apb_regs #(.ADDR_W(4), .BAUD_RST(11'd325)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .tx_fifo_dataIn   (tx_fifo_dataIn),
    .tx_fifo_writeEn  (tx_fifo_writeEn),
    .tx_fifo_Full     (tx_fifo_Full),
    .rx_fifo_readEn   (rx_fifo_readEn),
    .rx_fifo_Empty    (rx_fifo_Empty),
    .rx_fifo_dataOut  (rx_fifo_dataOut),
    .baud_final_value (baud_final_value),
    .irq              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic        full;
    logic        empty;
    logic [7:0]  rxd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_waits;
    int          exp_wr;
    int          exp_rd;
    logic [7:0]  exp_txd;
    logic [10:0] exp_baud;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int waits,
                      output int nwr, output int nrd, output logic [7:0] txd,
                      output logic both);
    bit done;
    done  = 0;
    rd    = 32'hDEAD_BEEF;
    err   = 1'bx;
    waits = 0;
    nwr   = 0;
    nrd   = 0;
    txd   = 8'h00;
    both  = 1'b0;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    for (int cyc = 0; cyc < 6 && !done; cyc++) begin
      @(negedge clk);
      if (tx_fifo_writeEn) begin nwr++; txd = tx_fifo_dataIn; end
      if (rx_fifo_readEn) nrd++;
      if (tx_fifo_writeEn && rx_fifo_readEn) both = 1'b1;
      if (bus.pready) begin
        rd   = bus.prdata;
        err  = bus.pslverr;
        done = 1;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!done) waits = 99;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits, nwr, nrd;
  logic [7:0]  txd;
  logic        both;

  initial begin
    //           w  a     d             full empty rxd    exp_rdata       err waits wr rd txd    baud
    vecs[0]  = '{0, 4'h8, 32'h0,         0, 1, 8'h00, 32'h145,         0, 0, 0, 0, 8'h00, 11'h145};
    vecs[1]  = '{1, 4'h8, 32'h0000_0A2B, 0, 1, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[2]  = '{0, 4'h8, 32'h0,         0, 1, 8'h00, 32'h22B,         0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[3]  = '{0, 4'hB, 32'h0,         0, 1, 8'h00, 32'h22B,         0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[4]  = '{1, 4'h0, 32'h0000_005A, 0, 1, 8'h00, 32'h0,           0, 0, 1, 0, 8'h5A, 11'h22B};
    vecs[5]  = '{1, 4'h0, 32'h0000_00A5, 1, 1, 8'h00, 32'h0,           1, 0, 0, 0, 8'h00, 11'h22B};
    vecs[6]  = '{0, 4'h4, 32'h0,         0, 1, 8'h00, 32'h6,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[7]  = '{1, 4'h4, 32'h4,         0, 1, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[8]  = '{0, 4'h4, 32'h0,         1, 0, 8'h00, 32'h1,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[9]  = '{0, 4'h0, 32'h0,         0, 0, 8'hC3, 32'hC3,          0, 1, 0, 1, 8'h00, 11'h22B};
    vecs[10] = '{0, 4'h0, 32'h0,         0, 1, 8'h77, 32'h0,           1, 0, 0, 0, 8'h00, 11'h22B};
    vecs[11] = '{0, 4'h4, 32'h0,         0, 1, 8'h00, 32'hA,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[12] = '{1, 4'h4, 32'h8,         0, 1, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[13] = '{0, 4'h4, 32'h0,         0, 1, 8'h00, 32'h2,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[14] = '{1, 4'hC, 32'h1,         0, 1, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 11'h22B};
    vecs[15] = '{0, 4'hC, 32'h0,         0, 1, 8'h00, {31'h0, IRQ_ON}, 0, 0, 0, 0, 8'h00, 11'h22B};

    reset = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 4'h0; bus.pwdata = 32'h0;
    tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1; rx_fifo_dataOut = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset prdata",  bus.prdata, 32'h0);
    chk("reset pready",  {31'h0, bus.pready}, 32'h0);
    chk("reset pslverr", {31'h0, bus.pslverr}, 32'h0);
    chk("reset writeEn", {31'h0, tx_fifo_writeEn}, 32'h0);
    chk("reset readEn",  {31'h0, rx_fifo_readEn}, 32'h0);
    chk("reset dataIn",  {24'h0, tx_fifo_dataIn}, 32'h0);
    chk("reset baud",    {21'h0, baud_final_value}, 32'd325);
    chk("reset irq",     {31'h0, irq}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tx_fifo_Full    = vecs[i].full;
      rx_fifo_Empty   = vecs[i].empty;
      rx_fifo_dataOut = vecs[i].rxd;
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, rd, err, waits, nwr, nrd, txd, both);
      chk($sformatf("v%0d prdata", i),  rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d pslverr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d waits", i),   waits, vecs[i].exp_waits);
      chk($sformatf("v%0d writeEn cycles", i), nwr, vecs[i].exp_wr);
      chk($sformatf("v%0d readEn cycles", i),  nrd, vecs[i].exp_rd);
      chk($sformatf("v%0d strobe overlap", i), {31'h0, both}, 32'h0);
      chk($sformatf("v%0d baud", i), {21'h0, baud_final_value}, {21'h0, vecs[i].exp_baud});
      if (vecs[i].exp_wr > 0) chk($sformatf("v%0d dataIn", i), {24'h0, txd}, {24'h0, vecs[i].exp_txd});
    end

    // irq follows ~rx_fifo_Empty one cycle late when enabled
    tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq idle", {31'h0, irq}, 32'h0);
    @(posedge clk); #1; rx_fifo_Empty = 1'b0;
    @(negedge clk);
    chk("irq same cycle", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq asserted", {31'h0, irq}, {31'h0, IRQ_ON});
    @(posedge clk); #1; rx_fifo_Empty = 1'b1;
    @(negedge clk);
    chk("irq holds one cycle", {31'h0, irq}, {31'h0, IRQ_ON});
    @(negedge clk);
    chk("irq cleared", {31'h0, irq}, 32'h0);

    // Reset asserted while in RD_WAIT
    rx_fifo_Empty = 1'b0; rx_fifo_dataOut = 8'h3C;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 4'h0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    chk("rst-seq readEn in access", {31'h0, rx_fifo_readEn}, 32'h1);
    chk("rst-seq pready in access", {31'h0, bus.pready}, 32'h0);
    @(posedge clk); #1;
    chk("rst-seq pready in rd_wait", {31'h0, bus.pready}, 32'h1);
    chk("rst-seq prdata in rd_wait", bus.prdata, 32'h3C);
    reset = 1'b0;
    #1;
    chk("rst-seq readEn dropped", {31'h0, rx_fifo_readEn}, 32'h0);
    chk("rst-seq pready dropped", {31'h0, bus.pready}, 32'h0);
    chk("rst-seq prdata dropped", bus.prdata, 32'h0);
    chk("rst-seq baud reset", {21'h0, baud_final_value}, 32'd325);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    xfer(1'b0, 4'h8, 32'h0, rd, err, waits, nwr, nrd, txd, both);
    chk("post-reset baud read", rd, 32'h145);
    chk("post-reset waits", waits, 0);

    // psel dropped during RD_WAIT: pop still completes once, FSM returns idle
    rx_fifo_Empty = 1'b0; rx_fifo_dataOut = 8'h81;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 4'h0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    chk("drop-seq readEn", {31'h0, rx_fifo_readEn}, 32'h1);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    chk("drop-seq readEn single", {31'h0, rx_fifo_readEn}, 32'h0);
    @(negedge clk);
    chk("drop-seq idle pready", {31'h0, bus.pready}, 32'h0);
    xfer(1'b0, 4'h4, 32'h0, rd, err, waits, nwr, nrd, txd, both);
    chk("drop-seq status", rd, 32'h0);
    chk("drop-seq readEn none", nrd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_apb_regs.md
Name: uart_apb_regs

Overview:
- APB3 slave register bridge directly upstream of the UART controller.
- Translates CPU bus transfers into UART-side signals:
  - TX FIFO pushes
  - RX FIFO pops
  - baud divisor programming
  - status reporting
- Outputs connect straight to the UART's tx_fifo_dataIn/tx_fifo_writeEn, rx_fifo_readEn and baud_final_value inputs; its FULL/EMPTY/dataOut feed back in.

Parameters:
- ADDR_W, 4, width of paddr (byte address; only bits [3:2] decoded, bits [1:0] ignored)
- BAUD_RST, 11'd325, reset value of the BAUD register

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (ACCESS phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  APB byte address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid when pready=1
- tx_fifo_dataIn  out  8  byte to UART TX FIFO
- tx_fifo_writeEn  out  1  one-cycle TX push strobe
- tx_fifo_Full  in  1  TX FIFO full
- rx_fifo_readEn  out  1  one-cycle RX pop strobe
- rx_fifo_Empty  in  1  RX FIFO empty
- rx_fifo_dataOut  in  8  RX FIFO head; valid the cycle after readEn
- baud_final_value  out  11  baud divisor to generator
- irq  out  1  interrupt (only with UART_APB_IRQ_EN; otherwise tied 0)

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE; prdata=0; pready=0; pslverr=0
  - tx_fifo_writeEn=0; rx_fifo_readEn=0; tx_fifo_dataIn=0
  - baud_final_value=BAUD_RST; sticky flags=0; irq=0
- Register map (paddr[3:2]):
  - 0x0 DATA:
    - W: pushes pwdata[7:0]
    - R: pops RX byte into prdata[7:0], upper bits 0
  - 0x1 STATUS:
    - R: bit0 tx_fifo_Full, bit1 rx_fifo_Empty, bit2 tx_ovf (sticky), bit3 rx_udf (sticky), others 0
    - W: write-1-to-clear on bits 2,3
  - 0x2 BAUD: RW, pwdata[10:0]; read returns zero-extended value
  - 0x3 IRQ_EN: see Optional Feature; without the feature, reads 0, writes ignored, pslverr=0
- FSM states: IDLE, ACCESS, RD_WAIT.
  - IDLE -> ACCESS when psel=1 & penable=0 (SETUP phase observed).
  - ACCESS, all transfers except DATA read:
    - pready=1 combinationally in the first ACCESS cycle (zero wait states)
    - side effects registered on that edge
    - -> IDLE
  - ACCESS, DATA read with rx_fifo_Empty=0:
    - rx_fifo_readEn=1 for exactly that cycle; pready=0
    - -> RD_WAIT
  - RD_WAIT:
    - prdata<=rx_fifo_dataOut; pready=1, pslverr=0
    - -> IDLE
    - Exactly one wait state.
  - ACCESS, DATA read with rx_fifo_Empty=1:
    - pready=1, pslverr=1, prdata=0, no readEn
    - rx_udf<=1
- DATA write:
  - tx_fifo_Full=0: tx_fifo_writeEn=1 for the single ACCESS cycle; tx_fifo_dataIn=pwdata[7:0] held that cycle.
  - tx_fifo_Full=1: no push; pslverr=1; tx_ovf<=1.
- Simultaneous events:
  - A sticky set and a W1C clear in the same cycle: set wins.
  - Full/Empty are sampled in the ACCESS cycle only.
- Strobes: readEn and writeEn are never asserted together and never for more than one cycle per transfer.
- Back-to-back transfers: a new SETUP is accepted in the cycle following pready=1.
- psel dropped mid-RD_WAIT: complete the pop anyway, return to IDLE. The byte is consumed; no bus response is required.
- Reset mid-transfer: all strobes drop immediately; FSM→IDLE.
- pslverr and prdata are meaningful only while pready=1; otherwise 0.

Optional Feature:
- Macro UART_APB_IRQ_EN.
- Defined:
  - IRQ_EN register bit0 = rx_not_empty enable, bit1 = tx_not_full enable, bit2 = error enable, reset 0.
  - irq is registered and asserts the cycle after any enabled condition holds: ~rx_fifo_Empty, ~tx_fifo_Full, or tx_ovf|rx_udf.
  - irq deasserts the cycle after the condition clears.
- Undefined: irq tied 0; IRQ_EN reads 0; no extra flops.

Test Plan:
- Reset -> all outputs 0, baud_final_value=325; read BAUD returns 0x145 with zero wait states.
- Write BAUD 0x0000_0A2B -> baud_final_value=11'h22B; readback 0x22B; pslverr=0.
- Write DATA 0x5A with Full=0 -> one-cycle tx_fifo_writeEn, tx_fifo_dataIn=0x5A, pready same cycle. Repeat with Full=1 -> no strobe, pslverr=1, STATUS bit2=1. Write STATUS 0x4 -> bit2=0.
- RX FIFO holding 0xC3, read DATA -> readEn pulse in ACCESS, pready=0, then pready=1 with prdata=0x000000C3. Read again with Empty=1 -> pslverr=1, prdata=0, STATUS bit3=1.
- Assert reset during RD_WAIT -> readEn/pready drop asynchronously; next transfer completes normally.
- With UART_APB_IRQ_EN: IRQ_EN=0x1, rx_fifo_Empty 1->0 -> irq=1 one cycle later; drain FIFO -> irq=0. Without the macro, irq stays 0 throughout.
